// File: rtl/fma_pkg.sv
// Shared types, constants and fixed-point helpers for the fp16 x int8 FMA datapath.
package fma_pkg;

    typedef logic [15:0] fp16_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_MERGE = 3'd3,
        ST_MWAIT = 3'd4,
        ST_OUT   = 3'd5
    } dot_state_t;

    localparam int         FMA_LAT   = 2;
    localparam fp16_t      FP16_ZERO = 16'h0000;
    localparam logic [7:0] INT8_ONE  = 8'h01;

    // Signed fixed point, LSB = 2^-24 (smallest fp16 subnormal); wide enough for act*w + acc.
    localparam int FX_W = 52;

    function automatic logic signed [FX_W-1:0] fp16_to_fx(input fp16_t x);
        logic [4:0]      e;
        logic [FX_W-1:0] mag;
        e = x[14:10];
        if (e == 5'd0) begin
            mag = {{(FX_W-10){1'b0}}, x[9:0]};
        end else begin
            mag = {{(FX_W-11){1'b0}}, 1'b1, x[9:0]} << (e - 5'd1);
        end
        return x[15] ? -$signed(mag) : $signed(mag);
    endfunction

    // Truncating normalizer: drops bits below the 11-bit significand, saturates to max finite.
    function automatic fp16_t fx_to_fp16(input logic signed [FX_W-1:0] s);
        logic            neg;
        logic [FX_W-1:0] mag;
        logic [FX_W-1:0] sh;
        int              p;
        neg = s[FX_W-1];
        mag = neg ? $unsigned(-s) : $unsigned(s);
        p   = 0;
        for (int i = 0; i < FX_W; i++) begin
            if (mag[i]) begin
                p = i;
            end
        end
        if (mag == {FX_W{1'b0}}) begin
            return FP16_ZERO;
        end else if (p >= 40) begin
            return {neg, 5'd30, 10'h3FF};
        end else if (p >= 10) begin
            sh = mag >> (p - 10);
            return {neg, 5'(p - 9), sh[9:0]};
        end else begin
            return {neg, 5'd0, mag[9:0]};
        end
    endfunction

endpackage

// File: rtl/fma_int8.sv
// Two-stage fp16 x int8 + fp16 fused multiply-add; operands in cycle t give acc_out in cycle t+2.
module fma_int8
    import fma_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  fp16_t      act,
    input  logic [7:0] w,
    input  fp16_t      acc,
    output fp16_t      acc_out
);

    logic signed [FX_W-1:0] w_act_fx;
    logic signed [FX_W-1:0] w_w_fx;
    logic signed [FX_W-1:0] w_acc_fx;
    logic signed [FX_W-1:0] r_prod;
    logic signed [FX_W-1:0] r_addend;
    fp16_t                  r_acc_out;

    assign w_act_fx = fp16_to_fx(act);
    assign w_w_fx   = {{(FX_W-8){w[7]}}, w};
    assign w_acc_fx = fp16_to_fx(acc);

    // Stage 1: exact product and aligned addend.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod   <= {FX_W{1'b0}};
            r_addend <= {FX_W{1'b0}};
        end else begin
            r_prod   <= w_act_fx * w_w_fx;
            r_addend <= w_acc_fx;
        end
    end

    // Stage 2: sum and normalize back to fp16.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_out <= FP16_ZERO;
        end else begin
            r_acc_out <= fx_to_fp16(r_prod + r_addend);
        end
    end

    assign acc_out = r_acc_out;

endmodule

// File: rtl/fma_int8_dot_seq.sv
// Dot-product sequencer: streams element pairs through one fma_int8 using two interleaved
// partial sums so the 2-cycle FMA latency never stalls, then merges them on the same FMA.
module fma_int8_dot_seq
    import fma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_act,
    input  logic [7:0]       in_w,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data
);

    dot_state_t       r_state;
    dot_state_t       w_state_nxt;
    logic [LEN_W-1:0] r_rem;
    fp16_t            r_part [2];
    logic             r_slot;
    logic             r_v1;
    logic             r_s1;
    logic             r_v2;
    logic             r_s2;
    logic             r_mwait_cnt;
    fp16_t            r_res_data;

    logic             w_xfer;
    fp16_t            w_fma_act;
    logic [7:0]       w_fma_w;
    fp16_t            w_fma_acc;
    fp16_t            w_acc_out;

    assign in_ready  = (r_state == ST_MAC) && (r_rem != {LEN_W{1'b0}});
    assign w_xfer    = in_valid && in_ready;
    assign busy      = (r_state != ST_IDLE);
    assign res_valid = (r_state == ST_OUT);
    assign res_data  = r_res_data;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DRAIN exits once only the final writeback (v2) is left in flight.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (len == {LEN_W{1'b0}}) ? ST_OUT : ST_MAC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (r_rem == {LEN_W{1'b0}}) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_MAC;
                end
            end
            ST_DRAIN: begin
                if (!r_v1) begin
                    w_state_nxt = ST_MERGE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_MERGE: w_state_nxt = ST_MWAIT;
            ST_MWAIT: begin
                if (r_mwait_cnt) begin
                    w_state_nxt = ST_OUT;
                end else begin
                    w_state_nxt = ST_MWAIT;
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FMA operand select; a result landing this cycle in the active slot is forwarded.
    always_comb begin
        w_fma_act = FP16_ZERO;
        w_fma_w   = 8'h00;
        w_fma_acc = FP16_ZERO;
        if (w_xfer) begin
            w_fma_act = in_act;
            w_fma_w   = in_w;
            w_fma_acc = (r_v2 && (r_s2 == r_slot)) ? w_acc_out : r_part[r_slot];
        end else if (r_state == ST_MERGE) begin
            w_fma_act = r_part[0];
            w_fma_w   = INT8_ONE;
            w_fma_acc = r_part[1];
        end else begin
            w_fma_act = FP16_ZERO;
        end
    end

    // Tag pipe, partial sums, element counter and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem       <= {LEN_W{1'b0}};
            r_part[0]   <= FP16_ZERO;
            r_part[1]   <= FP16_ZERO;
            r_slot      <= 1'b0;
            r_v1        <= 1'b0;
            r_s1        <= 1'b0;
            r_v2        <= 1'b0;
            r_s2        <= 1'b0;
            r_mwait_cnt <= 1'b0;
            r_res_data  <= FP16_ZERO;
        end else begin
            r_v1 <= w_xfer;
            r_s1 <= r_slot;
            r_v2 <= r_v1;
            r_s2 <= r_s1;
            if (r_v2) begin
                r_part[r_s2] <= w_acc_out;
            end
            case (r_state)
                ST_IDLE: begin
                    r_mwait_cnt <= 1'b0;
                    if (start) begin
                        r_rem     <= len;
                        r_part[0] <= FP16_ZERO;
                        r_part[1] <= FP16_ZERO;
                        r_slot    <= 1'b0;
                        if (len == {LEN_W{1'b0}}) begin
                            r_res_data <= FP16_ZERO;
                        end
                    end
                end
                ST_MAC: begin
                    if (w_xfer) begin
                        r_slot <= ~r_slot;
                        r_rem  <= r_rem - {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_MWAIT: begin
                    if (r_mwait_cnt) begin
                        r_res_data  <= w_acc_out;
                        r_mwait_cnt <= 1'b0;
                    end else begin
                        r_mwait_cnt <= 1'b1;
                    end
                end
                default: begin
                    r_mwait_cnt <= 1'b0;
                end
            endcase
        end
    end

    fma_int8 u_fma (
        .clk     (clk),
        .reset   (reset),
        .act     (w_fma_act),
        .w       (w_fma_w),
        .acc     (w_fma_acc),
        .acc_out (w_acc_out)
    );

endmodule

// File: tb/tb_fma_int8_dot_seq.sv
// Directed self-checking bench for fma_int8_dot_seq with hand-computed fp16 results.
module tb_fma_int8_dot_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] len;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_act;
    logic [7:0]  in_w;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        ir_mon = 1'b0;
    logic        ir_seen = 1'b0;
    logic [15:0] a_tab [8];
    logic [7:0]  w_tab [8];

    fma_int8_dot_seq #(.LEN_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .in_w      (in_w),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ir_mon && in_ready) begin
            ir_seen <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode 0: in_valid constant, 1: toggling, 2: random bubbles
    task automatic run_dot(input int n, input int mode, output logic [15:0] res, output int lat);
        int   idx   = 0;
        int   guard = 0;
        int   c0    = -1;
        logic v;
        @(negedge clk);
        start = 1'b1;
        len   = 16'(n);
        if (n == 0) c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (idx < n && guard < 400) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (guard % 2 == 0);
            else                v = ($urandom_range(0, 2) != 0);
            in_valid = v;
            in_act   = a_tab[idx];
            in_w     = w_tab[idx];
            if (v && in_ready) begin
                if (c0 < 0) c0 = cyc;
                idx++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        guard = 0;
        while (!res_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("res_valid_seen", 32'(res_valid), 32'd1);
        res = res_data;
        lat = cyc - c0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq("hs_res_valid_low", 32'(res_valid), 32'd0);
        check_eq("hs_busy_low", 32'(busy), 32'd0);
    endtask

    task automatic load_t1();
        for (int i = 0; i < 4; i++) begin
            a_tab[i] = 16'h3C00;
            w_tab[i] = 8'(i + 1);
        end
    endtask

    initial begin
        logic [15:0] res;
        logic [15:0] held;
        int          lat;
        int          rv_cnt;

        reset = 1'b1; start = 1'b0; len = 16'd0; in_valid = 1'b0;
        in_act = 16'h0000; in_w = 8'h00; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_res_data", 32'(res_data), 32'd0);

        // 1: 1*1 + 1*2 + 1*3 + 1*4 = 10.0
        load_t1();
        run_dot(4, 0, res, lat);
        check_eq("t1_data", 32'(res), 32'h4900);
        check_eq("t1_latency", 32'(lat), 32'd9);
        handshake();
        rv_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (res_valid) rv_cnt++;
        end
        check_eq("t1_single_valid", 32'(rv_cnt), 32'd0);

        // 2: 2.0 * -3 = -6.0
        a_tab[0] = 16'h4000; w_tab[0] = 8'hFD;
        run_dot(1, 0, res, lat);
        check_eq("t2_data", 32'(res), 32'hC600);
        check_eq("t2_latency", 32'(lat), 32'd6);
        handshake();

        // 0.5*127 + 0.5*-128 + 0.5*2 = 0.5
        a_tab[0] = 16'h3800; w_tab[0] = 8'h7F;
        a_tab[1] = 16'h3800; w_tab[1] = 8'h80;
        a_tab[2] = 16'h3800; w_tab[2] = 8'h02;
        run_dot(3, 0, res, lat);
        check_eq("mix_data", 32'(res), 32'h3800);
        handshake();

        // 3: empty vector
        ir_mon = 1'b1;
        run_dot(0, 0, res, lat);
        check_eq("t3_data", 32'(res), 32'h0000);
        check_eq("t3_latency", 32'(lat), 32'd1);
        handshake();
        ir_mon = 1'b0;
        check_eq("t3_no_in_ready", 32'(ir_seen), 32'd0);

        // 4: bubbles
        load_t1();
        run_dot(4, 1, res, lat);
        check_eq("t4_toggle_data", 32'(res), 32'h4900);
        handshake();
        run_dot(4, 2, res, lat);
        check_eq("t4_random_data", 32'(res), 32'h4900);
        handshake();

        // 5: back-pressure on the result with a stray start
        a_tab[0] = 16'h4000; w_tab[0] = 8'hFD;
        run_dot(1, 0, res, lat);
        held = res_data;
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            len   = 16'd3;
            @(negedge clk);
            check_eq("t5_data_stable", 32'(res_data), 32'(held));
            check_eq("t5_busy", 32'(busy), 32'd1);
            check_eq("t5_valid_held", 32'(res_valid), 32'd1);
        end
        start = 1'b0;
        check_eq("t5_data", 32'(held), 32'hC600);
        handshake();
        @(negedge clk);
        check_eq("t5_start_ignored", 32'(busy), 32'd0);

        // 6: reset after two of four elements
        load_t1();
        start = 1'b1; len = 16'd4;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_act = a_tab[0]; in_w = w_tab[0];
        @(negedge clk);
        in_act = a_tab[1]; in_w = w_tab[1];
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_res_valid", 32'(res_valid), 32'd0);
        check_eq("t6_res_data", 32'(res_data), 32'd0);
        rv_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (res_valid) rv_cnt++;
        end
        check_eq("t6_no_stale_valid", 32'(rv_cnt), 32'd0);
        run_dot(4, 0, res, lat);
        check_eq("t6_data", 32'(res), 32'h4900);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
